// File: rtl/pong_pkg.sv
// Shared definitions for the pong game: FSM encoding, screen geometry, colours.
// No ports; imported by pong_ctrl and pong_render.
// Also holds the saturating paddle-move helper used for both paddles.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_SCORE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Screen geometry (visible and total scan counts).
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  // Paddle columns (inclusive).
  localparam int PADL_X0 = 16;
  localparam int PADL_X1 = 23;
  localparam int PADR_X0 = 616;
  localparam int PADR_X1 = 623;

  // Ball home position while waiting to serve.
  localparam int BALL_X0 = 316;
  localparam int BALL_Y0 = 236;

  // Frames spent showing a point before the next serve.
  localparam int SCORE_FRAMES = 60;

  localparam logic [11:0] COL_BALL   = 12'hFFF;
  localparam logic [11:0] COL_PADDLE = 12'h0F0;
  localparam logic [11:0] COL_LINE   = 12'h888;
  localparam logic [11:0] COL_BG     = 12'h000;

  // One frame of paddle motion: opposing or idle buttons hold, result clamped.
  function automatic logic [9:0] paddle_move(input logic [9:0] y, input logic up,
                                             input logic dn, input int step,
                                             input int y_max);
    int t;
    t = int'(y);
    if (up && !dn)      t = t - step;
    else if (dn && !up) t = t + step;
    if (t < 0)          t = 0;
    else if (t > y_max) t = y_max;
    return 10'(t);
  endfunction

endpackage

// File: rtl/pong_if.sv
// Video-side bundle between the scan timing generator and the pong block.
// master: timing generator (drives scan position, video_on, frame_tick; takes rgb).
// slave : pong_ctrl (takes scan position and frame_tick; drives rgb).
interface pong_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        frame_tick;
  logic [11:0] rgb;

  modport master (output pixel_x, pixel_y, video_on, frame_tick, input rgb);
  modport slave  (input pixel_x, pixel_y, video_on, frame_tick, output rgb);
endinterface

// File: rtl/pong_render.sv
// Pixel renderer: hit-tests ball, paddles and centre line, picks the colour.
// Ports: clk/rst, scan position + video_on in, object positions in, rgb out.
// rgb is registered: exactly one clk after the scan inputs; 000 outside video_on.
module pong_render
  import pong_pkg::*;
#(
  parameter int PADDLE_H = 64,
  parameter int BALL_SZ  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  paddle_l_y,
  input  logic [9:0]  paddle_r_y,
  output logic [11:0] rgb
);

  int px, py, bx, by, pl, pr;
  logic ball_hit, pad_hit, line_hit;
  logic [11:0] rgb_n;

  always_comb begin
    px = int'(pixel_x);
    py = int'(pixel_y);
    bx = int'(ball_x);
    by = int'(ball_y);
    pl = int'(paddle_l_y);
    pr = int'(paddle_r_y);

    ball_hit = (px >= bx) && (px < bx + BALL_SZ) && (py >= by) && (py < by + BALL_SZ);
    pad_hit  = ((px >= PADL_X0) && (px <= PADL_X1) && (py >= pl) && (py < pl + PADDLE_H)) ||
               ((px >= PADR_X0) && (px <= PADR_X1) && (py >= pr) && (py < pr + PADDLE_H));
    // Dashed net: 4 px wide, drawn on alternate 16-line bands.
    line_hit = (px >= 318) && (px <= 321) && !pixel_y[4];

    rgb_n = COL_BG;
    if (!video_on)     rgb_n = COL_BG;
    else if (ball_hit) rgb_n = COL_BALL;
    else if (pad_hit)  rgb_n = COL_PADDLE;
    else if (line_hit) rgb_n = COL_LINE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb <= COL_BG;
    else     rgb <= rgb_n;
  end

endmodule

// File: rtl/pong_ctrl.sv
// Pong game top: FSM, paddles, ball physics and scoring, updated once per frame_tick.
// Ports: clk/rst, vid (pong_if.slave: scan in, rgb out), buttons, score_l/score_r, game_state.
// Optional macro PONG_AI_EN: right paddle tracks the ball instead of r_up/r_dn.
module pong_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_H    = 64,
  parameter int BALL_SZ     = 8,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_STEP   = 2,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst,
  pong_if.slave      vid,
  input  logic       l_up,
  input  logic       l_dn,
  input  logic       r_up,
  input  logic       r_dn,
  input  logic       serve,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] game_state
);

  localparam int PAD_MAX    = V_ACTIVE - PADDLE_H;
  localparam int BALL_X_MAX = H_ACTIVE - BALL_SZ;
  localparam int BALL_Y_MAX = V_ACTIVE - BALL_SZ;

  state_t     state;
  logic [9:0] paddle_l_y, paddle_r_y, ball_x, ball_y;
  logic       dir_x, dir_y;      // 1 = right / down
  logic [5:0] score_cnt;

  logic r_mv_up, r_mv_dn;
`ifdef PONG_AI_EN
  int ai_target;
  always_comb begin
    ai_target = int'(ball_y) + BALL_SZ/2 - PADDLE_H/2;
    r_mv_up   = ai_target < int'(paddle_r_y);
    r_mv_dn   = ai_target > int'(paddle_r_y);
  end
`else
  assign r_mv_up = r_up;
  assign r_mv_dn = r_dn;
`endif

  // Candidate ball position for this frame, with wall clamp applied to y.
  int   nx, ny, ny_c, pl, pr;
  logic dir_y_n, hit_l, hit_r, miss_l, miss_r;

  always_comb begin
    pl      = int'(paddle_l_y);
    pr      = int'(paddle_r_y);
    nx      = int'(ball_x) + (dir_x ? BALL_STEP : -BALL_STEP);
    ny      = int'(ball_y) + (dir_y ? BALL_STEP : -BALL_STEP);
    ny_c    = ny;
    dir_y_n = dir_y;
    if (ny <= 0) begin
      ny_c    = 0;
      dir_y_n = 1'b1;
    end else if (ny >= BALL_Y_MAX) begin
      ny_c    = BALL_Y_MAX;
      dir_y_n = 1'b0;
    end
    // A paddle only deflects a ball travelling toward it.
    hit_l  = !dir_x && (nx <= PADL_X1) && (nx + BALL_SZ - 1 >= PADL_X0) &&
             (ny_c <= pl + PADDLE_H - 1) && (ny_c + BALL_SZ - 1 >= pl);
    hit_r  =  dir_x && (nx <= PADR_X1) && (nx + BALL_SZ - 1 >= PADR_X0) &&
             (ny_c <= pr + PADDLE_H - 1) && (ny_c + BALL_SZ - 1 >= pr);
    miss_l = nx <= 0;
    miss_r = nx >= BALL_X_MAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      score_l    <= '0;
      score_r    <= '0;
      score_cnt  <= '0;
      paddle_l_y <= 10'(PAD_MAX / 2);
      paddle_r_y <= 10'(PAD_MAX / 2);
      ball_x     <= 10'(BALL_X0);
      ball_y     <= 10'(BALL_Y0);
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
    end else if (vid.frame_tick) begin
      if (state != ST_OVER) begin
        paddle_l_y <= paddle_move(paddle_l_y, l_up, l_dn, PADDLE_STEP, PAD_MAX);
        paddle_r_y <= paddle_move(paddle_r_y, r_mv_up, r_mv_dn, PADDLE_STEP, PAD_MAX);
      end
      case (state)
        ST_IDLE: begin
          ball_x <= 10'(BALL_X0);
          ball_y <= 10'(BALL_Y0);
          if (serve) state <= ST_SERVE;
        end
        ST_SERVE: begin
          ball_x <= 10'(BALL_X0);
          ball_y <= 10'(BALL_Y0);
          if (!serve) state <= ST_PLAY;
        end
        ST_PLAY: begin
          ball_y <= 10'(ny_c);
          dir_y  <= dir_y_n;
          if (hit_l) begin
            dir_x  <= 1'b1;
            ball_x <= 10'(PADL_X1 + 1);
          end else if (hit_r) begin
            dir_x  <= 1'b0;
            ball_x <= 10'(PADR_X0 - BALL_SZ);
          end else if (miss_l) begin
            // Right player scores; next serve heads toward the scorer.
            ball_x    <= '0;
            dir_x     <= 1'b1;
            score_r   <= (score_r == 4'(WIN_SCORE)) ? score_r : score_r + 4'd1;
            score_cnt <= '0;
            state     <= ST_SCORE;
          end else if (miss_r) begin
            ball_x    <= 10'(BALL_X_MAX);
            dir_x     <= 1'b0;
            score_l   <= (score_l == 4'(WIN_SCORE)) ? score_l : score_l + 4'd1;
            score_cnt <= '0;
            state     <= ST_SCORE;
          end else begin
            ball_x <= 10'(nx);
          end
        end
        ST_SCORE: begin
          if (score_cnt == 6'(SCORE_FRAMES - 1)) begin
            ball_x <= 10'(BALL_X0);
            ball_y <= 10'(BALL_Y0);
            state  <= (score_l == 4'(WIN_SCORE) || score_r == 4'(WIN_SCORE)) ? ST_OVER : ST_SERVE;
          end else begin
            score_cnt <= score_cnt + 6'd1;
          end
        end
        ST_OVER: begin
          if (serve) begin
            score_l <= '0;
            score_r <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign game_state = state;

  pong_render #(.PADDLE_H(PADDLE_H), .BALL_SZ(BALL_SZ)) u_render (
    .clk        (clk),
    .rst        (rst),
    .pixel_x    (vid.pixel_x),
    .pixel_y    (vid.pixel_y),
    .video_on   (vid.video_on),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .rgb        (vid.rgb)
  );

endmodule

// File: tb/tb_pong_ctrl.sv
// Directed bench for pong_ctrl with an expectation queue.
// Expected values are pushed when stimulus is applied and popped when the DUT answers.
// Drives on/samples at the falling clock edge.
module tb_pong_ctrl;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0, serve = 1'b0;
  logic [3:0] score_l, score_r;
  logic [2:0] game_state;

  pong_if vid();

  pong_ctrl dut (
    .clk(clk), .rst(rst), .vid(vid),
    .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn), .serve(serve),
    .score_l(score_l), .score_r(score_r), .game_state(game_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  // Pixel probe table: x, y, video_on, expected colour (paddles at 412 / 204, ball home).
  int rx[12] = '{320, 320, 319,  20,  620,  620, 320, 318, 323, 324,  20,  20};
  int ry[12] = '{  0,   0, 236, 412,  204,  203,  16,  15, 243, 243, 475, 476};
  int rv[12] = '{  1,   0,   1,   1,    1,    1,   1,   1,   1,   1,   1,   1};
  int rc[12] = '{'h888, 'h000, 'hFFF, 'h0F0, 'h0F0, 'h000, 'h000, 'h888, 'hFFF, 'h000, 'h0F0, 'h000};

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_underflow observed=%0h", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    vid.frame_tick = 1'b1;
    @(negedge clk);
    vid.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input logic [2:0] target, input int limit, output int n);
    n = 0;
    while (game_state !== target && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    vid.pixel_x = '0; vid.pixel_y = '0; vid.video_on = 1'b0; vid.frame_tick = 1'b0;

    // Reset; a frame_tick with a button held during reset must do nothing.
    l_dn = 1'b1;
    repeat (2) @(negedge clk);
    vid.frame_tick = 1'b1;
    @(negedge clk);
    vid.frame_tick = 1'b0;
    l_dn = 1'b0;
    push("rst_state", 32'(ST_IDLE)); push("rst_score_l", 0); push("rst_score_r", 0);
    push("rst_pad_l", 208); push("rst_pad_r", 208); push("rst_ball_x", 316);
    push("rst_ball_y", 236); push("rst_dir_x", 1); push("rst_dir_y", 1); push("rst_rgb", 0);
    rst = 1'b0;
    @(negedge clk);
    pop(32'(game_state)); pop(32'(score_l)); pop(32'(score_r));
    pop(32'(dut.paddle_l_y)); pop(32'(dut.paddle_r_y)); pop(32'(dut.ball_x));
    pop(32'(dut.ball_y)); pop(32'(dut.dir_x)); pop(32'(dut.dir_y)); pop(32'(vid.rgb));

    // Left paddle down: 52 frames from 208 to the 416 floor, then stays.
    l_dn = 1'b1;
    push("pad_l_51", 412); ticks(51); pop(32'(dut.paddle_l_y));
    push("pad_l_52", 416); tick();     pop(32'(dut.paddle_l_y));
    push("pad_l_60", 416); ticks(8);   pop(32'(dut.paddle_l_y));
    l_up = 1'b1;
    push("pad_l_both", 416); ticks(5); pop(32'(dut.paddle_l_y));
    l_dn = 1'b0; r_up = 1'b1;
    push("pad_l_up", 412); push("pad_r_up", 204); tick();
    pop(32'(dut.paddle_l_y)); pop(32'(dut.paddle_r_y));
    l_up = 1'b0; r_up = 1'b0;

    // Renderer: back-to-back pixels, each answer one clk after its pixel.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i > 0) pop(32'(vid.rgb));
      vid.pixel_x  = 10'(rx[i]);
      vid.pixel_y  = 10'(ry[i]);
      vid.video_on = (rv[i] != 0);
      push($sformatf("rgb_%0d_%0d_v%0d", rx[i], ry[i], rv[i]), 32'(rc[i]));
    end
    @(negedge clk);
    pop(32'(vid.rgb));
    vid.video_on = 1'b0;

    // Serve press/release: IDLE -> SERVE -> PLAY, then ball +2,+2 per frame.
    serve = 1'b1;
    push("serve_state", 32'(ST_SERVE)); tick(); pop(32'(game_state));
    serve = 1'b0;
    push("play_state", 32'(ST_PLAY)); push("play_x0", 316); push("play_y0", 236);
    tick(); pop(32'(game_state)); pop(32'(dut.ball_x)); pop(32'(dut.ball_y));
    push("play_x1", 318); push("play_y1", 238); tick(); pop(32'(dut.ball_x)); pop(32'(dut.ball_y));
    push("play_x2", 320); push("play_y2", 240); tick(); pop(32'(dut.ball_x)); pop(32'(dut.ball_y));

    // Asynchronous reset mid-PLAY, with the scan on the ball and a frame_tick pending.
    vid.pixel_x = 10'd320; vid.pixel_y = 10'd240; vid.video_on = 1'b1;
    push("mid_state", 32'(ST_IDLE)); push("mid_ball_x", 316); push("mid_ball_y", 236);
    push("mid_pad_l", 208); push("mid_pad_r", 208); push("mid_rgb", 0);
    @(posedge clk);
    #2 rst = 1'b1;
    vid.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    pop(32'(game_state)); pop(32'(dut.ball_x)); pop(32'(dut.ball_y));
    pop(32'(dut.paddle_l_y)); pop(32'(dut.paddle_r_y)); pop(32'(vid.rgb));
    @(negedge clk);
    vid.frame_tick = 1'b0; vid.video_on = 1'b0;
    rst = 1'b0;

    // Rally: right paddle parked top, left paddle parked top.
    l_up = 1'b1; r_up = 1'b1;
    serve = 1'b1; tick(); serve = 1'b0; tick();
    push("r1_frames", 158); push("r1_score_l", 1); push("r1_score_r", 0); push("r1_ball_x", 632);
    wait_state(ST_SCORE, 300, n);
    pop(32'(n)); pop(32'(score_l)); pop(32'(score_r)); pop(32'(dut.ball_x));
    push("score_hold_59", 32'(ST_SCORE)); ticks(59); pop(32'(game_state));
    push("score_exit_60", 32'(ST_SERVE)); tick(); pop(32'(game_state));
    push("r2_dir_x", 0); push("r2_dir_y", 0); push("r2_state", 32'(ST_PLAY));
    tick(); pop(32'(dut.dir_x)); pop(32'(dut.dir_y)); pop(32'(game_state));
    push("wall_pre_y", 2); push("wall_pre_dir", 0); ticks(117);
    pop(32'(dut.ball_y)); pop(32'(dut.dir_y));
    push("wall_y", 0); push("wall_dir", 1); tick(); pop(32'(dut.ball_y)); pop(32'(dut.dir_y));
    push("pad_pre_x", 24); push("pad_pre_dir", 0); ticks(28);
    pop(32'(dut.ball_x)); pop(32'(dut.dir_x));
    push("pad_x", 24); push("pad_dir", 1); push("pad_y", 58);
    tick(); pop(32'(dut.ball_x)); pop(32'(dut.dir_x)); pop(32'(dut.ball_y));

    // Full game: left paddle parked bottom, right paddle top; points alternate L, R.
    do_reset();
    l_up = 1'b0; l_dn = 1'b1; r_up = 1'b1;
    serve = 1'b1; tick(); serve = 1'b0;
    for (int p = 1; p <= 17; p++) begin
      push($sformatf("pt%0d_score_l", p), 32'((p + 1) / 2));
      push($sformatf("pt%0d_score_r", p), 32'(p / 2));
      push($sformatf("pt%0d_state", p), 32'(ST_SCORE));
      wait_state(ST_SCORE, 300, n);
      pop(32'(score_l)); pop(32'(score_r)); pop(32'(game_state));
      push($sformatf("pt%0d_after", p), (p < 17) ? 32'(ST_SERVE) : 32'(ST_OVER));
      ticks(60);
      pop(32'(game_state));
    end
    l_dn = 1'b0; l_up = 1'b1;
    push("over_hold", 32'(ST_OVER)); push("over_pad_frozen", 416);
    tick(); pop(32'(game_state)); pop(32'(dut.paddle_l_y));
    l_up = 1'b0;
    serve = 1'b1;
    push("restart_state", 32'(ST_IDLE)); push("restart_score_l", 0); push("restart_score_r", 0);
    tick(); pop(32'(game_state)); pop(32'(score_l)); pop(32'(score_r));
    serve = 1'b0;

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
